axis_lane_addsat: RTL and testbench

AXIS_LANE_ADDSAT -- requirements
Module: axis_lane_addsat

---
 rtl/axis_lane_addsat_if.sv | 27 ++
 rtl/axis_lane_addsat.sv | 193 +++++++++++++++++++
 tb/tb_axis_lane_addsat.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_lane_addsat_if.sv
// AXI-Stream bundle shared by the lane add/saturate block and its neighbours.
// tuser carries one saturation flag per lane on the master side only.
interface axis_lane_addsat_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4
);
  logic                          tvalid;
  logic                          tready;
  logic [LANES*DATA_WIDTH-1:0]   tdata;
  logic                          tlast;
  logic [LANES-1:0]              tuser;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_lane_addsat.sv
// Per-lane add / saturating add / saturating subtract of a constant on an AXI-Stream.
// Results are computed at acceptance and held in an output register backed by one skid slot.
module axis_lane_addsat #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter bit          SIGNED     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_WIDTH-1:0] cfg_const,
  axis_lane_addsat_if.slave     s_axis,
  axis_lane_addsat_if.master    m_axis,
  output logic [31:0]           beat_count
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned BW = LANES * DATA_WIDTH;

  localparam logic [W-1:0] MaxVal = SIGNED ? {1'b0, {(W-1){1'b1}}} : {W{1'b1}};
  localparam logic [W-1:0] MinVal = SIGNED ? {1'b1, {(W-1){1'b0}}} : {W{1'b0}};

  typedef enum logic [1:0] {
    ModePass   = 2'd0,
    ModeWrap   = 2'd1,
    ModeSatAdd = 2'd2,
    ModeSatSub = 2'd3
  } mode_e;

  mode_e mode;
  assign mode = mode_e'(cfg_mode);

  // ---------------------------------------------------------------------------
  // Lane datapath: combinational result for the beat currently on s_axis.
  // ---------------------------------------------------------------------------
  logic [BW-1:0]    res_data;
  logic [LANES-1:0] res_sat;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0] lane_in;
    logic [W:0]   a_ext;
    logic [W:0]   b_ext;
    logic [W:0]   sum;
    logic [W:0]   diff;
    logic         add_ovf;
    logic         sub_ovf;
    logic [W-1:0] add_clamp;
    logic [W-1:0] sub_clamp;
    logic [W-1:0] lane_res;
    logic         lane_sat;

    assign lane_in = s_axis.tdata[i*W +: W];

    // One extra bit holds the exact result; sign-extend only for signed lanes.
    assign a_ext = {SIGNED & lane_in[W-1], lane_in};
    assign b_ext = {SIGNED & cfg_const[W-1], cfg_const};
    assign sum   = a_ext + b_ext;
    assign diff  = a_ext - b_ext;

    always_comb begin
      if (SIGNED) begin
        add_ovf   = sum[W] ^ sum[W-1];
        sub_ovf   = diff[W] ^ diff[W-1];
        add_clamp = sum[W] ? MinVal : MaxVal;
        sub_clamp = diff[W] ? MinVal : MaxVal;
      end else begin
        // Unsigned: carry out means overflow, borrow means underflow.
        add_ovf   = sum[W];
        sub_ovf   = diff[W];
        add_clamp = MaxVal;
        sub_clamp = MinVal;
      end
    end

    always_comb begin
      lane_res = lane_in;
      lane_sat = 1'b0;
      unique case (mode)
        ModePass: begin
          lane_res = lane_in;
        end
        ModeWrap: begin
          lane_res = sum[W-1:0];
        end
        ModeSatAdd: begin
          lane_res = add_ovf ? add_clamp : sum[W-1:0];
          lane_sat = add_ovf;
        end
        ModeSatSub: begin
          lane_res = sub_ovf ? sub_clamp : diff[W-1:0];
          lane_sat = sub_ovf;
        end
      endcase
    end

    assign res_data[i*W +: W] = lane_res;
    assign res_sat[i]         = lane_sat;
  end

  // ---------------------------------------------------------------------------
  // Output register plus skid slot.
  // ---------------------------------------------------------------------------
  logic             out_valid_q, out_valid_d;
  logic [BW-1:0]    out_data_q,  out_data_d;
  logic             out_last_q,  out_last_d;
  logic [LANES-1:0] out_user_q,  out_user_d;

  logic             skid_valid_q, skid_valid_d;
  logic [BW-1:0]    skid_data_q,  skid_data_d;
  logic             skid_last_q,  skid_last_d;
  logic [LANES-1:0] skid_user_q,  skid_user_d;

  logic             ready_q, ready_d;
  logic [31:0]      count_q, count_d;

  logic             accept;
  logic             take;

  assign accept = s_axis.tvalid & ready_q;
  assign take   = out_valid_q & m_axis.tready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_user_d   = out_user_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_user_d  = skid_user_q;

    if (!out_valid_q || take) begin
      // Output slot frees up this edge: skid has priority to preserve order.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        out_user_d   = skid_user_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_data_d = res_data;
          out_last_d = s_axis.tlast;
          out_user_d = res_sat;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = res_data;
      skid_last_d  = s_axis.tlast;
      skid_user_d  = res_sat;
    end

    // ready is registered, so it only drops once the skid slot is actually full.
    ready_d = ~skid_valid_d;
    count_d = count_q + {31'b0, take};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_user_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_user_q  <= '0;
      ready_q      <= 1'b0;
      count_q      <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_user_q   <= out_user_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_user_q  <= skid_user_d;
      ready_q      <= ready_d;
      count_q      <= count_d;
    end
  end

  assign s_axis.tready = ready_q;
  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tdata  = out_data_q;
  assign m_axis.tlast  = out_last_q;
  assign m_axis.tuser  = out_user_q;
  assign beat_count    = count_q;

endmodule

// File: tb/tb_axis_lane_addsat.sv
// Bench for axis_lane_addsat: unsigned and signed instances share one stimulus stream
// and are checked every cycle against a queue-based arithmetic model.
module tb_axis_lane_addsat;

  localparam int DW = 8;
  localparam int LN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode;
  logic [7:0]  cst;
  logic        in_valid;
  logic        in_last;
  logic [31:0] in_data;
  logic        m_rdy;
  logic [31:0] cnt_u;
  logic [31:0] cnt_s;

  always #5 clk = ~clk;

  axis_lane_addsat_if #(.DATA_WIDTH(DW), .LANES(LN)) s_u ();
  axis_lane_addsat_if #(.DATA_WIDTH(DW), .LANES(LN)) m_u ();
  axis_lane_addsat_if #(.DATA_WIDTH(DW), .LANES(LN)) s_s ();
  axis_lane_addsat_if #(.DATA_WIDTH(DW), .LANES(LN)) m_s ();

  assign s_u.tvalid = in_valid;
  assign s_u.tdata  = in_data;
  assign s_u.tlast  = in_last;
  assign s_u.tuser  = '0;
  assign s_s.tvalid = in_valid;
  assign s_s.tdata  = in_data;
  assign s_s.tlast  = in_last;
  assign s_s.tuser  = '0;
  assign m_u.tready = m_rdy;
  assign m_s.tready = m_rdy;

  axis_lane_addsat #(.DATA_WIDTH(DW), .LANES(LN), .SIGNED(1'b0)) dut_u (
    .clk       (clk),
    .rst       (rst),
    .cfg_mode  (mode),
    .cfg_const (cst),
    .s_axis    (s_u),
    .m_axis    (m_u),
    .beat_count(cnt_u)
  );

  axis_lane_addsat #(.DATA_WIDTH(DW), .LANES(LN), .SIGNED(1'b1)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .cfg_mode  (mode),
    .cfg_const (cst),
    .s_axis    (s_s),
    .m_axis    (m_s),
    .beat_count(cnt_s)
  );

  typedef struct packed {
    logic [31:0] du;
    logic [3:0]  uu;
    logic [31:0] ds;
    logic [3:0]  us;
    logic        last;
  } item_t;

  item_t       q[$];
  logic [31:0] exp_cnt;
  bit          armed;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain integer arithmetic: interpret lanes, compute exact result, clamp to range.
  function automatic void model(input logic [31:0] d, input logic [1:0] md, input logic [7:0] c,
                                input bit sgn, output logic [31:0] r, output logic [3:0] u);
    longint a, b, v, lo, hi;
    r  = '0;
    u  = '0;
    lo = sgn ? -128 : 0;
    hi = sgn ? 127 : 255;
    for (int i = 0; i < 4; i++) begin
      a = longint'(d[i*8 +: 8]);
      b = longint'(c);
      if (sgn && a > 127) a = a - 256;
      if (sgn && b > 127) b = b - 256;
      case (md)
        2'd0:    v = a;
        2'd1:    v = a + b;
        2'd2:    v = a + b;
        default: v = a - b;
      endcase
      if (md >= 2'd2) begin
        if (v > hi) begin
          v = hi;
          u[i] = 1'b1;
        end else if (v < lo) begin
          v = lo;
          u[i] = 1'b1;
        end
      end
      r[i*8 +: 8] = 8'(v);
    end
  endfunction

  // Per-cycle compare, then advance the model to the upcoming rising edge.
  always @(negedge clk) begin : monitor
    bit    exp_rdy;
    item_t it;
    if (rst) begin
      chk("rst_s_tready", {s_u.tready, s_s.tready}, 0);
      chk("rst_m_tvalid", {m_u.tvalid, m_s.tvalid}, 0);
      chk("rst_m_tdata", {m_u.tdata, m_s.tdata}, 0);
      chk("rst_tlast_tuser", {m_u.tlast, m_u.tuser, m_s.tlast, m_s.tuser}, 0);
      chk("rst_beat_count", {cnt_u, cnt_s}, 0);
      q.delete();
      exp_cnt = '0;
      armed   = 1'b0;
    end else begin
      exp_rdy = armed && (q.size() < 2);
      chk("s_tready", {s_u.tready, s_s.tready}, {exp_rdy, exp_rdy});
      chk("m_tvalid", {m_u.tvalid, m_s.tvalid}, {2{q.size() > 0}});
      if (q.size() > 0) begin
        chk("u_tdata", m_u.tdata, q[0].du);
        chk("u_tuser", m_u.tuser, q[0].uu);
        chk("s_tdata", m_s.tdata, q[0].ds);
        chk("s_tuser", m_s.tuser, q[0].us);
        chk("tlast", {m_u.tlast, m_s.tlast}, {2{q[0].last}});
      end
      chk("beat_count", {cnt_u, cnt_s}, {exp_cnt, exp_cnt});
      if (q.size() > 0 && m_rdy) begin
        void'(q.pop_front());
        exp_cnt = exp_cnt + 1;
      end
      if (exp_rdy && in_valid) begin
        model(in_data, mode, cst, 1'b0, it.du, it.uu);
        model(in_data, mode, cst, 1'b1, it.ds, it.us);
        it.last = in_last;
        q.push_back(it);
      end
      armed = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  u;
    logic [7:0]  pick [4];
    pick[0] = 8'h00; pick[1] = 8'h7F; pick[2] = 8'h80; pick[3] = 8'hFF;

    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    mode = 2'd0; cst = 8'h00; m_rdy = 1'b1;

    // Pin the model with hand-computed vectors.
    model(32'hFFF52000, 2'd2, 8'h10, 1'b0, r, u);
    chk("pin_unsigned_satadd", {u, r}, {4'b1100, 32'hFFFF3010});
    model(32'h007F8480, 2'd3, 8'h05, 1'b1, r, u);
    chk("pin_signed_satsub", {u, r}, {4'b0011, 32'hFB7A8080});
    model(32'h000000FF, 2'd1, 8'h01, 1'b0, r, u);
    chk("pin_wrap", {u, r}, {4'b0000, 32'h01010100});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("ready_low_before_edge", s_u.tready, 1'b0);
    tick();
    chk("ready_after_rst", s_u.tready, 1'b1);

    // Unsigned saturating add, one-cycle latency.
    mode = 2'd2; cst = 8'h10; in_data = 32'hFFF52000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sat_add_valid", m_u.tvalid, 1'b1);
    chk("sat_add_data", m_u.tdata, 32'hFFFF3010);
    chk("sat_add_user", m_u.tuser, 4'b1100);

    // Signed saturating subtract.
    mode = 2'd3; cst = 8'h05; in_data = 32'h007F8480; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("signed_sub_data", m_s.tdata, 32'hFB7A8080);
    chk("signed_sub_user", m_s.tuser, 4'b0011);

    // Wrap and pass-through.
    mode = 2'd1; cst = 8'h01; in_data = 32'h000000FF; in_valid = 1'b1;
    tick();
    chk("wrap_data", {m_u.tuser, m_u.tdata}, {4'b0000, 32'h01010100});
    mode = 2'd0; cst = 8'h33; in_data = 32'hA5C30FF0;
    tick();
    in_valid = 1'b0;
    chk("pass_data", {m_u.tdata, m_s.tdata}, {32'hA5C30FF0, 32'hA5C30FF0});
    chk("pass_user", {m_u.tuser, m_s.tuser}, 8'h00);

    // Eight back-to-back beats, TLAST only on the last.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_data = $urandom; mode = 2'($urandom); cst = 8'($urandom);
      in_last = (i == 7); in_valid = 1'b1;
      tick();
      chk("stream_valid", m_u.tvalid, 1'b1);
      chk("stream_tlast", m_u.tlast, (i == 7));
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk("stream_count", cnt_u, 32'd8);
    chk("stream_drained", m_u.tvalid, 1'b0);

    // Back-pressure: fill output + skid, hold, then release.
    mode = 2'd0; cst = 8'h00; m_rdy = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = (i == 0) ? 32'h11111111 : (i == 1) ? 32'h22222222 : 32'h33333333;
      tick();
      chk("bp_hold_data", m_u.tdata, 32'h11111111);
      if (i >= 1) chk("bp_ready_low", s_u.tready, 1'b0);
    end
    m_rdy = 1'b1;
    tick();
    chk("bp_skid_to_out", m_u.tdata, 32'h22222222);
    chk("bp_ready_back", s_u.tready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_in_order", m_u.tdata, 32'h33333333);
    tick();
    chk("bp_drained", m_u.tvalid, 1'b0);

    // Randomized traffic with corner constants mixed in.
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = $urandom;
      in_last  = 1'($urandom);
      mode     = 2'($urandom);
      cst      = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 8'($urandom);
      m_rdy    = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0;
    m_rdy    = 1'b1;
    repeat (3) tick();

    // Asynchronous reset with two beats stored.
    m_rdy = 1'b0; in_valid = 1'b1; in_data = 32'hCAFEF00D;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("pre_rst_full", s_u.tready, 1'b0);
    chk("pre_rst_count_nonzero", (cnt_u != 0), 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {m_u.tvalid, m_s.tvalid}, 0);
    chk("async_rst_count", {cnt_u, cnt_s}, 0);
    tick();
    rst = 1'b0;
    m_rdy = 1'b1;
    tick();
    mode = 2'd2; cst = 8'h10; in_data = 32'hFFF52000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_data", m_u.tdata, 32'hFFFF3010);
    chk("post_rst_user", m_u.tuser, 4'b1100);
    tick();
    chk("post_rst_count", cnt_u, 32'd1);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
